// File: rtl/riscv_icache_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_icache_pkg : shared constants, FSM states and field-width helpers      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_icache_pkg;

  localparam int XLEN               = 32;
  localparam int DEF_LINES          = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    REPLAY   = 2'd3
  } icache_state_t;

  function automatic int tag_width(input int lines, input int words);
    return XLEN - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_icache_if.sv
// +----------------------------------------------------------------------------+
// | riscv_icache_if : line-refill bus between the instruction cache and memory   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface riscv_icache_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface

`default_nettype wire

// File: rtl/riscv_icache_data_array.sv
// +----------------------------------------------------------------------------+
// | icache_data_array : synchronous-read data/tag SRAM wrapper, one write port   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache_data_array
  import riscv_icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int IDX_W          = $clog2(LINES),
  parameter int OFF_W          = $clog2(WORDS_PER_LINE),
  parameter int TAG_W          = tag_width(LINES, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             wr_tag_en,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];

  // The tag is written alongside the final data word, so one port suffices.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
      if (wr_tag_en) begin
        tag_mem[wr_index] <= wr_tag;
      end
    end
    if (rd_en) begin
      rd_data <= data_mem[{rd_index, rd_offset}];
      rd_tag  <= tag_mem[rd_index];
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_icache.sv
// +----------------------------------------------------------------------------+
// | riscv_icache : direct-mapped instruction cache, 1-cycle hit, line refill     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module riscv_icache
  import riscv_icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          icache_addr,
  input  logic                 icache_re,
  output logic [31:0]          icache_dout,
  output logic                 stall,
  input  logic                 flush,
  riscv_icache_if.master       mem
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = tag_width(LINES, WORDS_PER_LINE);
  localparam int TAG_LSB = OFF_W + IDX_W + 2;

  icache_state_t    state, state_next;
  logic [31:2]      req_addr;
  logic             lookup_pending;
  logic             flush_pending;
  logic [OFF_W-1:0] beat_cnt;
  logic [LINES-1:0] valid;
  logic [31:0]      dout_q;

  logic [31:0]      rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_en;
  logic [IDX_W-1:0] rd_index;
  logic [OFF_W-1:0] rd_offset;

  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             hit, miss, accept;
  logic             refill_wr, last_beat, flush_apply;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^icache_addr[1:0];

  assign req_index   = req_addr[TAG_LSB-1:OFF_W+2];
  assign req_tag     = req_addr[31:TAG_LSB];

  // Lookup result is only meaningful the cycle after the array was read.
  assign hit         = lookup_pending && valid[req_index] && (rd_tag == req_tag);
  assign miss        = lookup_pending && !hit;
  assign stall       = (state != IDLE) || miss;
  assign accept      = (state == IDLE) && icache_re && !stall;
  assign icache_dout = hit ? rd_data : dout_q;

  assign refill_wr   = (state == REFILL) && mem.mem_resp_valid;
  assign last_beat   = refill_wr && (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign flush_apply = (state == IDLE) && (flush || flush_pending);

  assign mem.mem_req_valid = (state == MISS_REQ);
  assign mem.mem_req_addr  = {req_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};

  always_comb begin
    rd_en     = accept || (state == REPLAY);
    rd_index  = icache_addr[TAG_LSB-1:OFF_W+2];
    rd_offset = icache_addr[OFF_W+1:2];
    if (state == REPLAY) begin
      rd_index  = req_index;
      rd_offset = req_addr[OFF_W+1:2];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (miss)               state_next = MISS_REQ;
      MISS_REQ: if (mem.mem_req_ready)  state_next = REFILL;
      REFILL:   if (last_beat)          state_next = REPLAY;
      REPLAY:                           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      req_addr       <= '0;
      lookup_pending <= 1'b0;
      flush_pending  <= 1'b0;
      beat_cnt       <= '0;
      valid          <= '0;
      dout_q         <= '0;
    end else begin
      state          <= state_next;
      lookup_pending <= accept || (state == REPLAY);
      dout_q         <= icache_dout;
      if (accept) begin
        req_addr <= icache_addr[31:2];
      end
      if (refill_wr) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      // A flush seen mid-miss waits until the replayed word has gone out.
      if (flush_apply) begin
        valid         <= '0;
        flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
      if (last_beat) begin
        valid[req_index] <= 1'b1;
      end
    end
  end

  icache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_W          (OFF_W),
    .TAG_W          (TAG_W)
  ) u_data_array (
    .clk       (clk),
    .rd_en     (rd_en),
    .rd_index  (rd_index),
    .rd_offset (rd_offset),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .wr_en     (refill_wr),
    .wr_index  (req_index),
    .wr_offset (beat_cnt),
    .wr_data   (mem.mem_resp_data),
    .wr_tag_en (last_beat),
    .wr_tag    (req_tag)
  );

endmodule

`default_nettype wire

// File: doc/riscv_icache.md
RISCV_ICACHE -- requirements
Module: riscv_icache

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped lines (power of two, 2..256).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, 2..8).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port icache_addr  input  32  fetch byte address from core; bits [1:0] ignored.
REQ-006 Port icache_re  input  1  fetch request this cycle.
REQ-007 Port icache_dout  output  32  instruction word for the previous accepted request.
REQ-008 Port stall  output  1  core must freeze PC and fetch/DX registers while high.
REQ-009 Port flush  input  1  invalidate all lines (fence.i).
REQ-010 Port mem_req_valid  output  1  line refill request to main memory.
REQ-011 Port mem_req_ready  input  1  memory accepts request.
REQ-012 Port mem_req_addr  output  32  line-aligned refill address.
REQ-013 Port mem_resp_valid  input  1  one refill beat valid.
REQ-014 Port mem_resp_data  input  32  refill word, beats in ascending word order.

Function
REQ-015 Address split SHALL be: word offset [W+1:2], index [W+I+1:W+2], tag [31:W+I+2], W=log2(WORDS_PER_LINE), I=log2(LINES).
REQ-016 FSM states SHALL be IDLE, MISS_REQ, REFILL, REPLAY.
REQ-017 IDLE: request accepted when icache_re=1 and stall=0; address latched; data/tag arrays read synchronously.
REQ-018 Hit (valid and tag match) SHALL drive icache_dout with the addressed word one cycle after acceptance, stall=0 (1-cycle latency, back-to-back hits every cycle).
REQ-019 Miss SHALL assert stall combinationally in the cycle after acceptance and move to MISS_REQ; icache_dout holds its prior value.
REQ-020 MISS_REQ: mem_req_valid=1, mem_req_addr = latched address with offset bits zeroed; stable until mem_req_ready=1, then REFILL.
REQ-021 REFILL: each mem_resp_valid writes mem_resp_data into word beat_cnt of the indexed line, beat_cnt increments; after beat WORDS_PER_LINE-1, tag written, valid set, go REPLAY.
REQ-022 REPLAY: array re-read with latched address, stall=1; next cycle IDLE with hit data on icache_dout and stall=0.
REQ-023 stall SHALL be 1 in MISS_REQ, REFILL, REPLAY and in the miss-detect cycle; 0 otherwise.
REQ-024 icache_re=0 in IDLE: no lookup, icache_dout holds, stall=0.
REQ-025 mem_resp_valid outside REFILL SHALL be ignored.
REQ-026 flush in IDLE clears all valid bits at the next edge; a same-cycle lookup misses.
REQ-027 flush outside IDLE SHALL be held pending and applied on return to IDLE, after the REPLAY hit is delivered.
REQ-028 Refilled line replacing a valid line with different tag SHALL overwrite it (no writeback).
REQ-029 beat_cnt SHALL wrap to 0 on REFILL exit.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE, stall=0, mem_req_valid=0, icache_dout=0 (bubble), beat_cnt=0, flush-pending=0, all valid bits 0.
REQ-031 Reset mid-refill SHALL abandon the line (valid stays 0); data/tag array contents need no reset.
REQ-032 First edge after deassertion SHALL accept a request normally.

Structure
REQ-033 State encoding, address-field widths and default parameters SHALL live in the shared riscv151 constants package.
REQ-034 Data/tag storage SHALL be one sub-module icache_data_array (synchronous-read, single-write-port SRAM wrapper); valid bits stay in flops in riscv_icache.

Verification
REQ-035 Cold miss: reset, re=1 addr 0x0000_1000 -> stall 1, mem_req_addr 0x0000_1000, 4 beats 0x11..0x44 -> icache_dout 0x11, stall 0 after REPLAY.
REQ-036 Hit stream: after REQ-035, re at 0x1004, 0x1008, 0x100C on consecutive cycles -> dout 0x22, 0x33, 0x44, stall never 1.
REQ-037 Conflict: fetch 0x0000_1400 (same index, new tag) -> miss, refill; refetch 0x1000 -> miss again.
REQ-038 Backpressure: mem_req_ready low 5 cycles -> mem_req_valid/addr stable, stall 1 throughout.
REQ-039 Flush: flush during REFILL -> REPLAY data delivered, then 0x1000 misses.
REQ-040 Reset after beat 2 of refill -> stall 0, mem_req_valid 0 immediately; later fetch of same line misses.
